// File: rtl/usr_rd_slave.sv
// usr_rd_slave: read/write arbiter plus byte-lane memory
// with a fixed-latency read data pipeline.
module usr_rd_slave #(
  parameter int AXI_DW      = 128,
  parameter int AXI_AW      = 32,
  parameter int AXI_SW      = 3,
  parameter int MEM_DEPTH   = 1024,
  parameter int SLV_WS      = 1,
  parameter int SLV_MAXSIZE = 4,
  parameter int ASI_ARB     = 0
) (
  input  logic                usr_clk,
  input  logic                usr_reset_n,
  input  logic                usr_rrequest,
  output logic                usr_rgrant,
  input  logic                usr_wrequest,
  output logic                usr_wgrant,
  input  logic                usr_re,
  input  logic [AXI_AW-1:0]   usr_raddr,
  input  logic [AXI_SW-1:0]   usr_rsize,
  input  logic                usr_rlast,
  output logic [AXI_DW-1:0]   usr_rdata,
  output logic                usr_rsize_error,
  input  logic                usr_we,
  input  logic [AXI_AW-1:0]   usr_waddr,
  input  logic [AXI_DW-1:0]   usr_wdata,
  input  logic [AXI_DW/8-1:0] usr_wstrb,
  input  logic                usr_wlast
);

  localparam int BW  = AXI_DW / 8;
  localparam int OFS = $clog2(BW);
  localparam int IW  = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_RD,
    ARB_WR
  } arb_e;

  arb_e state, state_nxt;
  logic last_rd, last_rd_nxt;

  logic [AXI_DW-1:0] mem [MEM_DEPTH];
  logic [IW-1:0]     ridx, widx;
  logic [AXI_DW-1:0] rd_word;
  logic              unused_addr;

  assign ridx    = usr_raddr[OFS +: IW];
  assign widx    = usr_waddr[OFS +: IW];
  assign rd_word = mem[ridx];

  // Only the word-index bits address the memory.
  assign unused_addr = ^{usr_raddr, usr_waddr};

  assign usr_rgrant = (state == ARB_RD);
  assign usr_wgrant = (state == ARB_WR);

  assign usr_rsize_error =
    usr_re && (usr_rsize > AXI_SW'(SLV_MAXSIZE));

  // Arbiter state and the side served most recently.
  always_ff @(posedge usr_clk) begin
    if (!usr_reset_n) begin
      state   <= ARB_IDLE;
      last_rd <= (ASI_ARB == 0);
    end else begin
      state   <= state_nxt;
      last_rd <= last_rd_nxt;
    end
  end

  // Next grant: fair alternation on contention,
  // release only on the owning side's last beat.
  always_comb begin
    state_nxt   = state;
    last_rd_nxt = last_rd;
    unique case (state)
      ARB_IDLE: begin
        if (usr_rrequest && usr_wrequest) begin
          state_nxt   = last_rd ? ARB_WR : ARB_RD;
          last_rd_nxt = !last_rd;
        end else if (usr_rrequest) begin
          state_nxt   = ARB_RD;
          last_rd_nxt = 1'b1;
        end else if (usr_wrequest) begin
          state_nxt   = ARB_WR;
          last_rd_nxt = 1'b0;
        end
      end
      ARB_RD: begin
        if (usr_re && usr_rlast) state_nxt = ARB_IDLE;
      end
      ARB_WR: begin
        if (usr_we && usr_wlast) state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Byte-masked write; the arbiter does not gate it.
  always_ff @(posedge usr_clk) begin
    if (usr_we) begin
      for (int i = 0; i < BW; i++) begin
        if (usr_wstrb[i])
          mem[widx][i*8 +: 8] <= usr_wdata[i*8 +: 8];
      end
    end
  end

  if (SLV_WS == 0) begin : g_comb
    logic [AXI_DW-1:0] hold_q;

    // Remember the last word so the output holds.
    always_ff @(posedge usr_clk) begin
      if (!usr_reset_n) hold_q <= '0;
      else if (usr_re)  hold_q <= rd_word;
    end

    assign usr_rdata = usr_re ? rd_word : hold_q;
  end else if (SLV_WS == 1) begin : g_one
    logic [AXI_DW-1:0] d_q;

    // Single registered stage that holds between reads.
    always_ff @(posedge usr_clk) begin
      if (!usr_reset_n) d_q <= '0;
      else if (usr_re)  d_q <= rd_word;
    end

    assign usr_rdata = d_q;
  end else begin : g_multi
    logic [SLV_WS-2:0] v_q;
    logic [AXI_DW-1:0] d_q [SLV_WS];

    // Each stage advances only on a valid word, so the
    // last stage holds the most recent completed read.
    always_ff @(posedge usr_clk) begin
      if (!usr_reset_n) begin
        v_q <= '0;
        for (int i = 0; i < SLV_WS; i++) d_q[i] <= '0;
      end else begin
        v_q[0] <= usr_re;
        for (int i = 1; i < SLV_WS - 1; i++)
          v_q[i] <= v_q[i-1];
        if (usr_re) d_q[0] <= rd_word;
        for (int i = 1; i < SLV_WS; i++)
          if (v_q[i-1]) d_q[i] <= d_q[i-1];
      end
    end

    assign usr_rdata = d_q[SLV_WS-1];
  end

endmodule

// File: tb/tb_usr_rd_slave.sv
// tb_usr_rd_slave: directed vectors with a behavioural
// reference model compared every cycle.
module tb_usr_rd_slave;

  localparam int DW    = 128;
  localparam int AW    = 32;
  localparam int SW    = 3;
  localparam int DEPTH = 1024;
  localparam int WS    = 2;
  localparam int MAXS  = 4;
  localparam int ARB   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          rrequest, rgrant, wrequest, wgrant;
  logic          re, rlast, we, wlast;
  logic [AW-1:0] raddr, waddr;
  logic [SW-1:0] rsize;
  logic [DW-1:0] rdata, wdata;
  logic          rsize_error;
  logic [15:0]   wstrb;

  usr_rd_slave #(
    .AXI_DW(DW), .AXI_AW(AW), .AXI_SW(SW),
    .MEM_DEPTH(DEPTH), .SLV_WS(WS),
    .SLV_MAXSIZE(MAXS), .ASI_ARB(ARB)
  ) dut (
    .usr_clk(clk),
    .usr_reset_n(rst_n),
    .usr_rrequest(rrequest),
    .usr_rgrant(rgrant),
    .usr_wrequest(wrequest),
    .usr_wgrant(wgrant),
    .usr_re(re),
    .usr_raddr(raddr),
    .usr_rsize(rsize),
    .usr_rlast(rlast),
    .usr_rdata(rdata),
    .usr_rsize_error(rsize_error),
    .usr_we(we),
    .usr_waddr(waddr),
    .usr_wdata(wdata),
    .usr_wstrb(wstrb),
    .usr_wlast(wlast)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, logic [DW-1:0] act,
                     logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: owner 0=none 1=read 2=write
  typedef struct {
    logic [DW-1:0] d;
    bit            k;
    int            due;
  } rd_t;

  int            owner = 0;
  bit            last_rd = 1'b0;
  logic [DW-1:0] mm [DEPTH];
  logic [15:0]   mk [DEPTH];
  rd_t           q [$];
  rd_t           r;
  logic [DW-1:0] exp_rd = '0;
  bit            exp_k = 1'b0;
  int            cyc = 0;
  bit            model_on = 1'b0;
  int            ri, wi;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      owner    = 0;
      last_rd  = (ARB == 0);
      q.delete();
      exp_rd   = '0;
      exp_k    = 1'b1;
      model_on = 1'b1;
    end else begin
      ri = int'(raddr / 16) % DEPTH;
      wi = int'(waddr / 16) % DEPTH;
      if (re) begin
        r.d   = mm[ri];
        r.k   = (mk[ri] == 16'hffff);
        r.due = cyc + WS - 1;
        q.push_back(r);
      end
      while (q.size() > 0 && q[0].due <= cyc) begin
        exp_rd = q[0].d;
        exp_k  = q[0].k;
        void'(q.pop_front());
      end
      if (we) begin
        for (int b = 0; b < 16; b++) begin
          if (wstrb[b]) begin
            mm[wi][b*8 +: 8] = wdata[b*8 +: 8];
            mk[wi][b] = 1'b1;
          end
        end
      end
      if (owner == 0) begin
        if (rrequest && wrequest)
          owner = last_rd ? 2 : 1;
        else if (rrequest)
          owner = 1;
        else if (wrequest)
          owner = 2;
        if (owner != 0) last_rd = (owner == 1);
      end else if (owner == 1 && re && rlast) begin
        owner = 0;
      end else if (owner == 2 && we && wlast) begin
        owner = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("rgrant", DW'(rgrant), DW'(owner == 1));
      chk("wgrant", DW'(wgrant), DW'(owner == 2));
      chk("rsize_error", DW'(rsize_error),
          DW'(re && (rsize > MAXS)));
      if (exp_k) chk("rdata", rdata, exp_rd);
    end
  end

  string seq;
  logic [DW-1:0] v_old, v_new, v_w0;

  initial begin
    for (int i = 0; i < DEPTH; i++) mk[i] = '0;
    rst_n = 1'b0; rrequest = 1'b0; wrequest = 1'b0;
    re = 1'b0; rlast = 1'b0; we = 1'b0; wlast = 1'b0;
    raddr = '0; waddr = '0; rsize = '0;
    wdata = '0; wstrb = '0;
    repeat (3) tick();
    chk("rst_rgrant", DW'(rgrant), '0);
    chk("rst_wgrant", DW'(wgrant), '0);
    chk("rst_rdata", rdata, '0);
    rst_n = 1'b1;

    // single read requester, 4-beat burst
    rrequest = 1'b1;
    tick();
    chk("r19_grant", DW'(rgrant), DW'(1));
    for (int i = 0; i < 4; i++) begin
      re = 1'b1; raddr = AW'(i * 16);
      rlast = (i == 3);
      if (i == 1) rrequest = 1'b0;
      tick();
    end
    re = 1'b0; rlast = 1'b0;
    chk("r19_release", DW'(rgrant), '0);
    tick();

    // continuous contention alternates W,R,W,R
    seq = "";
    rrequest = 1'b1; wrequest = 1'b1;
    for (int g = 0; g < 4; g++) begin
      tick();
      if (wgrant) begin
        seq = {seq, "W"};
        we = 1'b1; wlast = 1'b1;
        waddr = AW'(32'h100 + g * 16);
        wdata = {4{32'h1234_0000 + 32'(g)}};
        wstrb = '1;
      end else if (rgrant) begin
        seq = {seq, "R"};
        re = 1'b1; rlast = 1'b1;
        raddr = 32'h100;
      end
      tick();
      we = 1'b0; wlast = 1'b0;
      re = 1'b0; rlast = 1'b0;
      chk("r20_idle_gap", DW'({rgrant, wgrant}), '0);
    end
    n_tests++;
    if (seq != "WRWR") begin
      n_fail++;
      $display("FAIL r20_order: got %s expected WRWR", seq);
    end
    rrequest = 1'b0; wrequest = 1'b0;
    tick();

    // byte-strobe merge, read latency of WS cycles
    wrequest = 1'b1;
    tick();
    we = 1'b1; waddr = 32'h40;
    wdata = {16{8'hAA}}; wstrb = '1; wlast = 1'b0;
    tick();
    wdata = DW'(8'h55); wstrb = 16'h0001; wlast = 1'b1;
    tick();
    we = 1'b0; wlast = 1'b0; wrequest = 1'b0;
    rrequest = 1'b1;
    tick();
    re = 1'b1; raddr = 32'h40; rlast = 1'b1; rsize = 3'd4;
    tick();
    re = 1'b0; rlast = 1'b0; rrequest = 1'b0;
    chk("r21_not_yet", rdata, {4{32'h1234_0000}});
    tick();
    chk("r21_merge", rdata, {{15{8'hAA}}, 8'h55});

    // same-cycle write and read of one word
    v_old = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    v_new = 128'hfedc_ba98_7654_3210_ffee_ddcc_bbaa_9988;
    we = 1'b1; waddr = 32'h80; wdata = v_old; wstrb = '1;
    tick();
    wdata = v_new; re = 1'b1; raddr = 32'h80; rsize = '0;
    tick();
    we = 1'b0;
    tick();
    re = 1'b0;
    chk("r22_old", rdata, v_old);
    tick();
    chk("r22_new", rdata, v_new);

    // oversize code flags one cycle; address wraps
    v_w0 = 128'hc0de_0000_1111_2222_3333_4444_5555_6666;
    we = 1'b1; waddr = '0; wdata = v_w0; wstrb = '1;
    tick();
    we = 1'b0;
    re = 1'b1; raddr = AW'(DEPTH * 16); rsize = 3'd5;
    #1;
    chk("r23_err_on", DW'(rsize_error), DW'(1));
    tick();
    re = 1'b0; rsize = '0;
    #1;
    chk("r23_err_off", DW'(rsize_error), '0);
    tick();
    chk("r23_wrap", rdata, v_w0);

    // reset with reads in flight
    rrequest = 1'b1;
    tick();
    re = 1'b1; raddr = 32'h40; rlast = 1'b0;
    tick();
    raddr = 32'h80;
    tick();
    re = 1'b0; rst_n = 1'b0;
    tick();
    chk("r24_rgrant", DW'(rgrant), '0);
    chk("r24_wgrant", DW'(wgrant), '0);
    chk("r24_rdata", rdata, '0);
    rst_n = 1'b1; rrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r24_no_stale", rdata, '0);
    end
    tick();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
